sm_alu_arbiter: RTL

// - Shares one sign-magnitude subtractor (instance subtractor #(.N(N))) between two requesters.
// - Each requester issues an ADD or SUB on N-bit sign-magnitude operands: MSB = sign, rest = magnitude.
// - Arbitrates, sequences the operation through registered stages and returns the result with a

---
 rtl/sm_alu_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/sm_alu_arbiter.sv
// rtl/sm_alu_arbiter.sv - two-requester arbiter sharing one sign-magnitude subtractor
//
// subtractor: combinational sign-magnitude A - B.
//   i_a, i_b   [N-1:0]  operands, MSB = sign, [N-2:0] = magnitude
//   o_diff     [N-1:0]  result; a zero magnitude is always reported as +0
//   o_carry             carry out of the magnitude (only possible when signs differ)
//
// sm_alu_arbiter: accepts ADD/SUB requests from two requesters, runs one at a
// time through IDLE -> EXEC -> RESP and returns the result to the owner.
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_req_valid / o_req_ready   [1:0] request handshake, bit i = requester i
//   in_op                        [1:0] 0 = SUB (a-b), 1 = ADD (a+b)
//   in_a, in_b                   [2N-1:0] operands, requester i at [i*N +: N]
//   o_rsp_valid / in_rsp_ready   [1:0] response handshake, only the owner's bit counts
//   o_out, o_carry               registered result, held through RESP
//   o_busy                       high whenever an operation is in flight
// Build option ARB_ROUND_ROBIN_EN: round-robin between simultaneous requests;
// without it requester 0 has fixed priority.

module subtractor #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_diff,
    output logic         o_carry
);
    logic         w_sa, w_sb, w_diff_sign, w_ge, w_sign;
    logic [N-2:0] w_ma, w_mb, w_dif, w_mag;
    logic [N-1:0] w_add;

    assign w_sa        = i_a[N-1];
    assign w_sb        = i_b[N-1];
    assign w_ma        = i_a[N-2:0];
    assign w_mb        = i_b[N-2:0];
    assign w_diff_sign = w_sa ^ w_sb;

    // Opposite signs: magnitudes add, sign follows A.
    // Equal signs: magnitudes subtract, sign flips when |B| > |A|.
    assign w_add   = {1'b0, w_ma} + {1'b0, w_mb};
    assign w_ge    = (w_ma >= w_mb);
    assign w_dif   = w_ge ? (w_ma - w_mb) : (w_mb - w_ma);
    assign w_mag   = w_diff_sign ? w_add[N-2:0] : w_dif;
    assign w_sign  = w_diff_sign ? w_sa : (w_ge ? w_sa : ~w_sa);
    assign o_carry = w_diff_sign & w_add[N-1];
    assign o_diff  = (w_mag == '0) ? '0 : {w_sign, w_mag};
endmodule

module sm_alu_arbiter #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     in_req_valid,
    output logic [1:0]     o_req_ready,
    input  logic [1:0]     in_op,
    input  logic [2*N-1:0] in_a,
    input  logic [2*N-1:0] in_b,
    output logic [1:0]     o_rsp_valid,
    input  logic [1:0]     in_rsp_ready,
    output logic [N-1:0]   o_out,
    output logic           o_carry,
    output logic           o_busy
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t       r_state;
    logic [N-1:0] r_a, r_b, r_out;
    logic         r_op, r_owner, r_carry, r_busy;
    logic [1:0]   r_rsp_valid;

    logic [1:0]   w_grant;
    logic         w_prefer0, w_sel, w_accept;
    logic [N-1:0] w_b_eff, w_sub_out;
    logic         w_sub_carry;

`ifdef ARB_ROUND_ROBIN_EN
    // Last granted requester; reset to 1 so requester 0 wins the first tie.
    logic r_ptr;
    assign w_prefer0 = r_ptr;
`else
    assign w_prefer0 = 1'b1;
`endif

    always_comb begin
        w_grant = 2'b00;
        if (r_state == S_IDLE) begin
            if (in_req_valid[0] && (!in_req_valid[1] || w_prefer0))
                w_grant = 2'b01;
            else if (in_req_valid[1])
                w_grant = 2'b10;
        end
    end

    assign w_accept = |w_grant;
    assign w_sel    = w_grant[1];

    // ADD is performed as A - (-B).
    assign w_b_eff = r_op ? {~r_b[N-1], r_b[N-2:0]} : r_b;

    subtractor #(.N(N)) u_sub (
        .i_a     (r_a),
        .i_b     (w_b_eff),
        .o_diff  (w_sub_out),
        .o_carry (w_sub_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= 1'b0;
            r_owner     <= 1'b0;
            r_out       <= '0;
            r_carry     <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_valid <= 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
            r_ptr       <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_sel ? in_a[2*N-1:N] : in_a[N-1:0];
                        r_b     <= w_sel ? in_b[2*N-1:N] : in_b[N-1:0];
                        r_op    <= in_op[w_sel];
                        r_owner <= w_sel;
                        r_busy  <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                        r_ptr   <= w_sel;
`endif
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_out       <= w_sub_out;
                    r_carry     <= w_sub_carry;
                    r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (in_rsp_ready[r_owner]) begin
                        r_rsp_valid <= 2'b00;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 2'b00;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready = w_grant;
    assign o_rsp_valid = r_rsp_valid;
    assign o_out       = r_out;
    assign o_carry     = r_carry;
    assign o_busy      = r_busy;
endmodule
